// File: rtl/timer_ctrl_if.sv
// Register-decode and counter-side signal bundle for timer_ctrl.
// master: APB decode / counter side; slave: timer_ctrl.
interface timer_ctrl_if;
  logic       tcr_wr;
  logic [7:0] tcr_wdata;
  logic [1:0] tsr_clr;
  logic [7:0] cnt;
  logic [7:0] last_cnt;
  logic [7:0] tcr_rdata;
  logic       load;
  logic       en;
  logic       ud;
  logic       count_enable;
  logic       ovf_flag;
  logic       udf_flag;
  logic       irq;

  modport master (
    output tcr_wr, tcr_wdata, tsr_clr, cnt, last_cnt,
    input  tcr_rdata, load, en, ud, count_enable, ovf_flag, udf_flag, irq
  );

  modport slave (
    input  tcr_wr, tcr_wdata, tsr_clr, cnt, last_cnt,
    output tcr_rdata, load, en, ud, count_enable, ovf_flag, udf_flag, irq
  );
endinterface

// File: rtl/timer_ctrl.sv
// Timer control: TCR, load/run sequencing, prescaled count tick and
// sticky overflow/underflow status with registered interrupt request.
//
// state | meaning
// IDLE  | counter stopped, prescaler held at 0
// LOAD  | one-cycle load pulse to the counter
// RUN   | counter enabled, prescaler free-running
module timer_ctrl #(
  parameter int PSC_W = 3
) (
  input logic         clk_in,
  input logic         presetn,
  timer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       tcr_q, tcr_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [PSC_W-1:0] psc_mask;
  logic             load_q, load_dly_q;
  logic             en_q;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             irq_q, irq_d;
  logic             en_next;
  logic             ld_req;
  logic             det_mask;
  logic             ovf_det, udf_det;

  // Bit7 (load request) and bit2 (reserved) are never stored.
  always_comb begin
    tcr_d = tcr_q;
    if (bus.tcr_wr) tcr_d = bus.tcr_wdata & 8'h7B;
  end

  assign en_next = tcr_d[4];
  assign ld_req  = bus.tcr_wr & bus.tcr_wdata[7];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ld_req)                           state_d = LOAD;
        else if (bus.tcr_wr && bus.tcr_wdata[4]) state_d = RUN;
      end
      LOAD:    state_d = en_next ? RUN : IDLE;
      RUN: begin
        if (ld_req)        state_d = LOAD;
        else if (!en_next) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    psc_d = '0;
    if (state_q == RUN) psc_d = psc_q + PSC_W'(1);
  end

  always_comb begin
    case (tcr_q[1:0])
      2'b00:   psc_mask = PSC_W'(0);
      2'b01:   psc_mask = PSC_W'(1);
      2'b10:   psc_mask = PSC_W'(3);
      default: psc_mask = PSC_W'(7);
    endcase
  end

  // Loading 00/FF makes cnt/last_cnt look like a wrap for the load cycle and the one after.
  assign det_mask = load_q | load_dly_q;
  assign ovf_det  = !tcr_q[5] && (bus.last_cnt == 8'hFF) && (bus.cnt == 8'h00) && !det_mask;
  assign udf_det  =  tcr_q[5] && (bus.last_cnt == 8'h00) && (bus.cnt == 8'hFF) && !det_mask;

  always_comb begin
    ovf_d = ovf_det | (ovf_q & ~bus.tsr_clr[0]);
    udf_d = udf_det | (udf_q & ~bus.tsr_clr[1]);
    irq_d = (ovf_q & tcr_q[3]) | (udf_q & tcr_q[6]);
  end

  always_ff @(posedge clk_in or negedge presetn) begin
    if (!presetn) begin
      state_q    <= IDLE;
      tcr_q      <= 8'h00;
      psc_q      <= '0;
      load_q     <= 1'b0;
      load_dly_q <= 1'b0;
      en_q       <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tcr_q      <= tcr_d;
      psc_q      <= psc_d;
      load_q     <= (state_d == LOAD);
      load_dly_q <= load_q;
      en_q       <= (state_d == RUN) & tcr_d[4];
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.tcr_rdata    = tcr_q;
  assign bus.load         = load_q;
  assign bus.en           = en_q;
  assign bus.ud           = tcr_q[5];
  assign bus.count_enable = (state_q == RUN) && ((psc_q & psc_mask) == psc_mask);
  assign bus.ovf_flag     = ovf_q;
  assign bus.udf_flag     = udf_q;
  assign bus.irq          = irq_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl; counter values are driven as hand-picked vectors.
module tb_timer_ctrl;

  logic clk_in  = 1'b0;
  logic presetn = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  timer_ctrl_if bus ();

  timer_ctrl #(.PSC_W(3)) dut (
    .clk_in  (clk_in),
    .presetn (presetn),
    .bus     (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr_tcr(input logic [7:0] d);
    bus.tcr_wr    = 1'b1;
    bus.tcr_wdata = d;
    step();
    bus.tcr_wr    = 1'b0;
    bus.tcr_wdata = 8'h00;
  endtask

  task automatic cnt_vec(input logic [7:0] last, input logic [7:0] cur);
    bus.last_cnt = last;
    bus.cnt      = cur;
  endtask

  initial begin
    bus.tcr_wr    = 1'b0;
    bus.tcr_wdata = 8'h00;
    bus.tsr_clr   = 2'b00;
    bus.cnt       = 8'h00;
    bus.last_cnt  = 8'h00;
    #12;
    chk("rst_load", {7'b0, bus.load}, 8'h00);
    chk("rst_en", {7'b0, bus.en}, 8'h00);
    chk("rst_ce", {7'b0, bus.count_enable}, 8'h00);
    chk("rst_irq", {7'b0, bus.irq}, 8'h00);
    chk("rst_tcr", bus.tcr_rdata, 8'h00);
    presetn = 1'b1;
    step();

    // 1: load + enable at /1
    wr_tcr(8'h90);
    chk("t1_load_hi", {7'b0, bus.load}, 8'h01);
    chk("t1_en_in_load", {7'b0, bus.en}, 8'h00);
    chk("t1_rdata", bus.tcr_rdata, 8'h10);
    step();
    chk("t1_load_lo", {7'b0, bus.load}, 8'h00);
    chk("t1_en_run", {7'b0, bus.en}, 8'h01);
    chk("t1_ce_a", {7'b0, bus.count_enable}, 8'h01);
    step();
    chk("t1_ce_b", {7'b0, bus.count_enable}, 8'h01);
    chk("t1_load_once", {7'b0, bus.load}, 8'h00);

    // 2: /8 from a fresh RUN entry, then switch to /2 mid-run
    wr_tcr(8'h00);
    chk("t2_idle_en", {7'b0, bus.en}, 8'h00);
    wr_tcr(8'h13);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t2_div8_%0d", i), {7'b0, bus.count_enable}, (i % 8 == 7) ? 8'h01 : 8'h00);
      if (i < 15) step();
    end
    wr_tcr(8'h11);
    chk("t2_div2_0", {7'b0, bus.count_enable}, 8'h00);
    step();
    chk("t2_div2_1", {7'b0, bus.count_enable}, 8'h01);
    step();
    chk("t2_div2_2", {7'b0, bus.count_enable}, 8'h00);
    step();
    chk("t2_div2_3", {7'b0, bus.count_enable}, 8'h01);
    chk("t2_en", {7'b0, bus.en}, 8'h01);

    // 3: overflow, irq, clear
    wr_tcr(8'h98);
    chk("t3_load", {7'b0, bus.load}, 8'h01);
    step();
    cnt_vec(8'hFE, 8'hFF);
    step();
    chk("t3_no_ovf_yet", {7'b0, bus.ovf_flag}, 8'h00);
    cnt_vec(8'hFF, 8'h00);
    step();
    chk("t3_ovf_set", {7'b0, bus.ovf_flag}, 8'h01);
    chk("t3_irq_lag", {7'b0, bus.irq}, 8'h00);
    cnt_vec(8'h00, 8'h01);
    step();
    chk("t3_irq_set", {7'b0, bus.irq}, 8'h01);
    bus.tsr_clr = 2'b01;
    step();
    bus.tsr_clr = 2'b00;
    chk("t3_ovf_clr", {7'b0, bus.ovf_flag}, 8'h00);
    chk("t3_irq_hold", {7'b0, bus.irq}, 8'h01);
    step();
    chk("t3_irq_drop", {7'b0, bus.irq}, 8'h00);

    // 4: underflow with UDIE
    wr_tcr(8'hF0);
    chk("t4_ud", {7'b0, bus.ud}, 8'h01);
    step();
    cnt_vec(8'h02, 8'h01);
    step();
    cnt_vec(8'h01, 8'h00);
    step();
    cnt_vec(8'h00, 8'hFF);
    step();
    chk("t4_udf_set", {7'b0, bus.udf_flag}, 8'h01);
    chk("t4_ovf_quiet", {7'b0, bus.ovf_flag}, 8'h00);
    cnt_vec(8'hFF, 8'hFE);
    step();
    chk("t4_irq", {7'b0, bus.irq}, 8'h01);
    chk("t4_rdata", bus.tcr_rdata, 8'h70);
    bus.tsr_clr = 2'b10;
    step();
    bus.tsr_clr = 2'b00;
    chk("t4_udf_clr", {7'b0, bus.udf_flag}, 8'h00);

    // 5: load of 00 from FF is masked; set beats clear
    cnt_vec(8'hFE, 8'hFF);
    wr_tcr(8'h98);
    cnt_vec(8'hFF, 8'h00);
    step();
    cnt_vec(8'hFF, 8'h00);
    step();
    chk("t5_masked", {7'b0, bus.ovf_flag}, 8'h00);
    step();
    chk("t5_ovf_set", {7'b0, bus.ovf_flag}, 8'h01);
    bus.tsr_clr = 2'b01;
    step();
    chk("t5_set_wins", {7'b0, bus.ovf_flag}, 8'h01);
    cnt_vec(8'h00, 8'h01);
    step();
    bus.tsr_clr = 2'b00;
    chk("t5_cleared", {7'b0, bus.ovf_flag}, 8'h00);
    step();

    // 6: reset during LOAD, then during RUN with flags set
    wr_tcr(8'h98);
    chk("t6_load_hi", {7'b0, bus.load}, 8'h01);
    presetn = 1'b0;
    #1;
    chk("t6_rst_load", {7'b0, bus.load}, 8'h00);
    chk("t6_rst_tcr", bus.tcr_rdata, 8'h00);
    presetn = 1'b1;
    step();
    chk("t6_no_load_a", {7'b0, bus.load}, 8'h00);
    step();
    chk("t6_no_load_b", {7'b0, bus.load}, 8'h00);
    chk("t6_idle_en", {7'b0, bus.en}, 8'h00);
    wr_tcr(8'h18);
    chk("t6_run_en", {7'b0, bus.en}, 8'h01);
    cnt_vec(8'hFF, 8'h00);
    step();
    cnt_vec(8'h00, 8'h01);
    step();
    chk("t6_ovf", {7'b0, bus.ovf_flag}, 8'h01);
    chk("t6_irq", {7'b0, bus.irq}, 8'h01);
    presetn = 1'b0;
    #1;
    chk("t6_rst_ovf", {7'b0, bus.ovf_flag}, 8'h00);
    chk("t6_rst_irq", {7'b0, bus.irq}, 8'h00);
    chk("t6_rst_en", {7'b0, bus.en}, 8'h00);
    chk("t6_rst_ce", {7'b0, bus.count_enable}, 8'h00);
    presetn = 1'b1;
    step();
    chk("t6_post_load", {7'b0, bus.load}, 8'h00);
    chk("t6_post_en", {7'b0, bus.en}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
Control and sequencing block for the 8-bit timer counter. It holds the timer control register (TCR) and drives the counter's load, en, ud and count_enable inputs. It generates the count_enable tick from a programmable prescaler. It watches the counter's cnt/last_cnt pair to raise sticky overflow/underflow status flags and the interrupt request. It sits between the APB register decode and the counter.

Parameters:
PSC_W, 3, prescaler counter width; supports divide ratios up to 2**PSC_W.

Ports:
clk_in  input  1  timer clock
presetn  input  1  asynchronous active-low reset
tcr_wr  input  1  one-cycle TCR write strobe
tcr_wdata  input  8  TCR write data
tsr_clr  input  2  write-1-to-clear strobes: [0] ovf, [1] udf
cnt  input  8  counter current value
last_cnt  input  8  counter value delayed one cycle
tcr_rdata  output  8  TCR readback; bit7 always reads 0
load  output  1  counter load pulse
en  output  1  counter enable (TCR[4])
ud  output  1  count direction, 1 = down (TCR[5])
count_enable  output  1  prescaled count tick
ovf_flag  output  1  sticky overflow status
udf_flag  output  1  sticky underflow status
irq  output  1  interrupt request

Behaviour:
- Reset is presetn, asynchronous, active-low; clock is clk_in.
- Reset values: TCR=8'h00, FSM=IDLE, prescaler=0; load, en, ud, count_enable, ovf_flag, udf_flag and irq are all 0.
- TCR fields:
  - [7] LOAD request (self-clearing, never stored)
  - [6] UDIE, underflow interrupt enable
  - [5] UD
  - [4] EN
  - [3] OVIE, overflow interrupt enable
  - [2] reserved, reads 0
  - [1:0] CKS clock select
- On tcr_wr, bits [6:3] and [1:0] are written at the same edge.
- FSM states IDLE, LOAD, RUN:
  - IDLE: en=0. tcr_wr with bit7=1 -> LOAD. tcr_wr with bit4=1 and bit7=0 -> RUN.
  - LOAD: load=1 for exactly one cycle. Next state is RUN if TCR[4]=1, else IDLE. A tcr_wr arriving during LOAD updates TCR but does not extend or retrigger load.
  - RUN: tcr_wr with bit7=1 -> LOAD. TCR[4] cleared -> IDLE on the same edge the write is taken.
- Output decode: load is a registered output, high only in LOAD. en = TCR[4] while in RUN, else 0. ud = TCR[5].
- Prescaler:
  - PSC_W-bit free-running up-counter; increments only in RUN.
  - Held at 0 in IDLE and LOAD, so the first tick after a load or enable is deterministic.
- Divide ratios: CKS 00 -> /1, 01 -> /2, 10 -> /4, 11 -> /8.
- count_enable = (state==RUN) && ((psc & mask)==mask), where mask = divisor-1. It is combinational from registered state.
  - /1 gives count_enable high every RUN cycle.
  - /N gives a one-cycle pulse every N cycles; the first pulse comes N cycles after RUN entry.
- Changing CKS mid-run takes effect immediately; the prescaler is not reset and the next tick follows the new mask.
- Overflow detect: ud==0 && last_cnt==8'hFF && cnt==8'h00. This sets ovf_flag at the next edge.
- Underflow detect: ud==1 && last_cnt==8'h00 && cnt==8'hFF. This sets udf_flag at the next edge.
- Detection is masked while load=1 and for the cycle after, so loads of 00/FF never raise false flags.
- Flags are sticky until cleared by tsr_clr. If set and clear occur in the same cycle, set wins.
- irq is registered: irq = (ovf_flag & OVIE) | (udf_flag & UDIE). It follows flag or enable changes with one cycle latency.
- Reset mid-operation: everything returns to reset values immediately. A pending load is discarded.

Test Plan:
1. Reset, then write TCR=8'h90 (load+en, CKS=00) -> load high exactly one cycle; next cycle state RUN, en=1, count_enable continuously 1; tcr_rdata=8'h10.
2. Write TCR=8'h13 (en, CKS=11) -> count_enable pulses once every 8 cycles, first pulse 8 cycles after RUN entry; switching to CKS=01 mid-run gives pulses every 2 cycles.
3. Load FC, up-count at /1 with OVIE=1 -> cnt wraps FF->00; ovf_flag=1 one cycle after last_cnt==FF and cnt==00; irq=1 one cycle later; tsr_clr=2'b01 clears ovf_flag, then irq drops.
4. Load 02, UD=1, UDIE=1 -> udf_flag and irq assert after 00->FF; ovf_flag stays 0.
5. Load 00 while counting up from FF -> no ovf_flag (masked window). tsr_clr asserted on the same cycle as a new overflow detect -> flag remains 1.
6. Assert presetn low during LOAD and again during RUN with flags set -> all outputs 0 immediately; no load pulse after reset release.
